// File: rtl/dsp_pkg.sv
// Shared defaults and state type for the IQ power accumulator.
package dsp_pkg;

    localparam int PACC_WIDTH_DEF = 32;
    localparam int IQ_W_DEF       = 16;
    localparam int LOG2_N_DEF     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } pacc_state_t;

endpackage

// File: rtl/iq_square_sum.sv
// First pipeline stage: registers I^2 + Q^2 as an unsigned value with its valid bit.
module iq_square_sum
    import dsp_pkg::*;
#(
    parameter int IQ_W = IQ_W_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   valid_in,
    input  logic signed [IQ_W-1:0] i,
    input  logic signed [IQ_W-1:0] q,
    output logic                   valid_out,
    output logic [2*IQ_W-1:0]      sq
);

    logic signed [2*IQ_W-1:0] i_sq;
    logic signed [2*IQ_W-1:0] q_sq;

    // Each square is non-negative; their sum can reach 2**(2*IQ_W-1), so add unsigned.
    assign i_sq = (2*IQ_W)'(i) * (2*IQ_W)'(i);
    assign q_sq = (2*IQ_W)'(q) * (2*IQ_W)'(q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            sq        <= '0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                sq <= $unsigned(i_sq) + $unsigned(q_sq);
            end
        end
    end

endmodule

// File: rtl/iq_power_acc.sv
// Mean IQ power over windows of 2**LOG2_N samples, with a one-cycle strobe per result.
module iq_power_acc
    import dsp_pkg::*;
#(
    parameter int WIDTH  = PACC_WIDTH_DEF,
    parameter int IQ_W   = IQ_W_DEF,
    parameter int LOG2_N = LOG2_N_DEF
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sample_valid_in,
    input  logic signed [IQ_W-1:0] i_in,
    input  logic signed [IQ_W-1:0] q_in,
    input  logic                   clear_in,
    output logic [WIDTH-1:0]       power_out,
    output logic                   enable_out
);

    localparam int SQ_W  = 2 * IQ_W;
    localparam int ACC_W = SQ_W + LOG2_N;
    localparam logic [LOG2_N-1:0] LAST = {LOG2_N{1'b1}};
    localparam logic [LOG2_N-1:0] ONE  = LOG2_N'(1);

    logic              sq_valid;
    logic [SQ_W-1:0]   sq;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_sum;
    logic [LOG2_N-1:0] count;
    pacc_state_t       state;

    // Gating the stage-1 input makes a clear drop the sample arriving with it.
    iq_square_sum #(
        .IQ_W(IQ_W)
    ) u_square_sum (
        .clk      (clk),
        .rstn     (rstn),
        .valid_in (sample_valid_in & ~clear_in),
        .i        (i_in),
        .q        (q_in),
        .valid_out(sq_valid),
        .sq       (sq)
    );

    // LOG2_N guard bits hold N maximal squares, so the sum never wraps.
    assign acc_sum = acc + ACC_W'(sq);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            acc        <= '0;
            count      <= '0;
            power_out  <= '0;
            enable_out <= 1'b0;
        end else begin
            enable_out <= 1'b0;
            if (clear_in) begin
                state <= IDLE;
                acc   <= '0;
                count <= '0;
            end else begin
                case (state)
                    IDLE, EMIT: begin
                        if (sq_valid) begin
                            acc   <= ACC_W'(sq);
                            count <= ONE;
                            state <= ACCUM;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    ACCUM: begin
                        if (sq_valid) begin
                            count <= count + ONE;
                            if (count == LAST) begin
                                power_out  <= WIDTH'(acc_sum[ACC_W-1:LOG2_N]);
                                acc        <= '0;
                                enable_out <= 1'b1;
                                state      <= EMIT;
                            end else begin
                                acc <= acc_sum;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        acc   <= '0;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/iq_power_acc.md
IQ_POWER_ACC -- requirements
Module: iq_power_acc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the power_out width (unsigned, integer LSB).
REQ-002 The block SHALL have parameter IQ_W, default 16, giving the signed I/Q sample width; legal only when 2*IQ_W <= WIDTH.
REQ-003 The block SHALL have parameter LOG2_N, default 4, where the window length is N = 2**LOG2_N samples; legal range 1..8.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port sample_valid_in, input, 1 bit: i_in and q_in are valid this cycle.
REQ-007 The block SHALL have port i_in, input, IQ_W bits: signed in-phase sample.
REQ-008 The block SHALL have port q_in, input, IQ_W bits: signed quadrature sample.
REQ-009 The block SHALL have port clear_in, input, 1 bit: synchronous flush of the window in progress.
REQ-010 The block SHALL have port power_out, output, WIDTH bits: mean of I^2+Q^2 over the last completed window; drives the 10log10 stage's log10_in.
REQ-011 The block SHALL have port enable_out, output, 1 bit: one-cycle strobe marking power_out as new; drives the 10log10 stage's enable_in.

Function
REQ-012 Stage 1 SHALL register sq = i_in*i_in + q_in*q_in as an unsigned 2*IQ_W-bit value, together with a valid bit, on every cycle where sample_valid_in=1.
REQ-013 Stage 2 SHALL add each valid sq into an accumulator of 2*IQ_W+LOG2_N bits; wrap-around SHALL be impossible by construction.
REQ-014 A sample counter of LOG2_N bits SHALL increment on each stage-2 valid and wrap from N-1 to 0.
REQ-015 The FSM SHALL have states IDLE, ACCUM and EMIT; IDLE->ACCUM on the first stage-2 valid; ACCUM->EMIT when the counter reaches N-1 on a valid; EMIT->ACCUM if a stage-2 valid is present, otherwise EMIT->IDLE.
REQ-016 On the ACCUM->EMIT edge, power_out SHALL load (acc+sq)>>LOG2_N, zero-extended to WIDTH, the accumulator SHALL reset to 0, and enable_out SHALL be 1 for exactly that one EMIT cycle.
REQ-017 Latency from the clock edge sampling the Nth sample_valid_in to enable_out=1 SHALL be 2 cycles.
REQ-018 power_out SHALL hold its value between strobes.
REQ-019 Idle cycles (sample_valid_in=0) SHALL be allowed anywhere in a window without affecting the result.
REQ-020 A stage-2 valid arriving in the EMIT cycle SHALL be the first sample of the next window.
REQ-021 The spacing between enable_out pulses SHALL be at least N >= 2 cycles, meeting the downstream enable/idle cadence.
REQ-022 clear_in=1 SHALL zero the accumulator, the counter and the stage-1 valid, and SHALL force IDLE with no strobe; power_out is unchanged.
REQ-023 clear_in SHALL take priority over a simultaneous sample_valid_in or a window completion.

Reset
REQ-024 On rstn=0, power_out=0, enable_out=0, accumulator=0, counter=0, stage-1 valid=0 and FSM=IDLE SHALL apply immediately, independent of clk.
REQ-025 Reset mid-window SHALL discard the partial window; the first window after release SHALL start at the first valid sample.

Structure
REQ-026 Package dsp_pkg SHALL hold the IQ_W and LOG2_N defaults and the typedef enum pacc_state_t {IDLE, ACCUM, EMIT}.
REQ-027 Stage 1 SHALL be a sub-module iq_square_sum (clk, rstn, valid in/out, i, q, sq); the accumulator and FSM SHALL live in the top level.

Verification
REQ-028 The bench SHALL cover: assert rstn=0 mid-run -> power_out=0 and enable_out=0 immediately; after release, 16 samples I=1, Q=1 -> power_out=2.
REQ-029 The bench SHALL cover: 16 back-to-back samples I=3, Q=4 -> power_out=25, with a single enable_out pulse exactly 2 cycles after the 16th valid.
REQ-030 The bench SHALL cover: 16 samples I=Q=-32768 -> power_out=32'h8000_0000, with no wrap-around.
REQ-031 The bench SHALL cover: 16 samples I=-7, Q=0 with random idle gaps -> power_out=49, with exactly one strobe.
REQ-032 The bench SHALL cover: 10 samples I=100, then clear_in=1 together with a valid, then 16 samples I=1, Q=0 -> no strobe until the last of those 16, then power_out=1.
REQ-033 The bench SHALL cover: 32 continuous samples, first 16 of I=2 and next 16 of I=4 -> strobes with power_out=4 then 16, exactly 16 cycles apart.
